acc_exec: RTL and testbench
===========================

# acc_exec

Accumulator execution unit for the single-accumulator core; the consumer of the 3-bit accumulator-control code the decode stage produces. Each accepted instruction applies its control model to the 8-bit accumulator, the EQ flag, data memory, or the register-write port. Sits between decode and the register file, data memory, and PC logic. Memory models use a req/ack handshake and stall the front end.

## Interface
- No parameters. Widths are fixed: data 8, control 3, opcode 6.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  unit can accept; high only in IDLE
- acc_ctrl  in  3  control model from decode
- op  in  6  raw opcode; low bits select the function
- rs_idx  in  3  destination register index for model 7
- rs_val  in  8  source register value
- rt_val  in  8  second register value
- imm  in  8  immediate / memory address / jump target
- acc  out  8  accumulator
- eq_flag  out  1  result of the last EQ
- jump_valid  out  1  one-cycle redirect pulse
- jump_target  out  8  PC target, valid with jump_valid
- reg_we  out  1  one-cycle register-write pulse
- reg_waddr  out  3  register-write address
- reg_wdata  out  8  register-write data
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  8  memory address
- mem_wdata  out  8  store data
- mem_rdata  in  8  load data, valid with mem_ack
- mem_ack  in  1  memory completion
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky; set on acc_ctrl = 000

## Operation
- States:
  - IDLE: in_ready=1.
  - MEM: mem_req=1, in_ready=0.
- Acceptance: an instruction is accepted on a rising edge with in_valid && in_ready.
- Models, applied at the accepting edge unless noted:
  - 001 ALU: acc <= acc f B. B = imm when op[5:3]=010, else rs_val. f from op[1:0]: 00 add, 01 sub, 10 and, 11 or. Add and sub wrap modulo 256.
  - 010 unary:
    - op[5:3]=110 (JR): jump_valid pulse with jump_target=acc; acc is unchanged.
    - op[2:0]=101: acc <= acc<<1.
    - op[2:0]=110: acc <= acc>>1 (logical).
    - Any other op: no-op.
  - 011 EQ: eq_flag <= (rs_val==rt_val).
  - 100 jump: if eq_flag=1, jump_valid pulse with jump_target=imm, and eq_flag clears. If eq_flag=0, retires with no redirect.
  - 101 store: go to MEM with mem_we=1, mem_addr=imm, mem_wdata=acc.
  - 110 load: go to MEM with mem_we=0, mem_addr=imm. acc <= mem_rdata on the ack edge.
  - 111 LWRI: reg_we pulse with reg_waddr=rs_idx, reg_wdata=imm.
  - 000: illegal <= 1; no other state changes; done still pulses.
- MEM exit: on the mem_ack edge, return to IDLE. mem_addr, mem_we, and mem_wdata are held stable for the whole MEM stay.
- mem_ack while in IDLE is ignored.

## Timing
- Reset values: acc=0, eq_flag=0, illegal=0, state=IDLE, in_ready=1. All pulses, mem_req, mem_we, mem_addr, mem_wdata, reg_* and jump_target are 0.
- Non-memory models: one-cycle latency. Results and the done, jump_valid, or reg_we pulse are visible in the cycle after acceptance. Back-to-back issue is allowed every cycle.
- Memory models: mem_req rises the cycle after acceptance. The ack may arrive in that same cycle at the earliest. done and updated acc appear the cycle after the ack edge. Minimum occupancy is 2 cycles.
- in_valid while in MEM is not accepted; the producer holds the instruction.
- A reset assertion mid-MEM drops mem_req immediately (asynchronously) and returns to IDLE. The pending instruction is lost and produces no done.

## Configuration
- ACC_MEM_TIMEOUT_EN defined:
  - A 5-bit counter runs in MEM.
  - After 16 cycles with no ack, the unit aborts to IDLE: mem_req drops, acc is unchanged, illegal is set, and done pulses.
  - An ack in the same cycle as the timeout wins.
- ACC_MEM_TIMEOUT_EN undefined: MEM waits indefinitely and no counter exists.

## Test plan
- Reset, then ALU add: acc=0. Issue 001/op=000000 with rs_val=0xF0, then op=010000 with imm=0x20 → acc=0xF0, then 0x10 (wrap). done pulses each cycle.
- Unary shifts: acc=0x81. Issue 010/op=000101 → acc=0x02. Then issue 010/op=000110 → acc=0x01.
- EQ and jump: EQ with rs_val=rt_val=0x33 → eq_flag=1. Jump with imm=0x40 → jump_valid for one cycle, jump_target=0x40, eq_flag=0. A second jump → no redirect.
- Store then load:
  - Store with acc=0x5A, imm=0x10, ack after 3 cycles → mem_req held 3 cycles with mem_we=1, addr=0x10, wdata=0x5A; in_ready=0 throughout.
  - Load with the ack returning mem_rdata=0xC3 → acc=0xC3.
- LWRI and illegal: LWRI with rs_idx=5, imm=0x7E → reg_we pulse, waddr=5, wdata=0x7E. acc_ctrl=000 → illegal=1 sticky, acc unchanged.
- Reset mid-MEM with ACC_MEM_TIMEOUT_EN defined:
  - Asserting rst_n=0 during MEM → mem_req=0 at once, state IDLE, no done.
  - A load that is never acked → abort after 16 cycles with illegal=1 and done.

Source files
------------

// File: rtl/acc_exec_if.sv
// Instruction issue bundle from decode into the accumulator execution unit.
// Valid/ready handshake: an instruction transfers on a clock edge with in_valid && in_ready.
interface acc_exec_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] acc_ctrl;
    logic [5:0] op;
    logic [2:0] rs_idx;
    logic [7:0] rs_val;
    logic [7:0] rt_val;
    logic [7:0] imm;

    modport master (
        output in_valid, acc_ctrl, op, rs_idx, rs_val, rt_val, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, acc_ctrl, op, rs_idx, rs_val, rt_val, imm,
        output in_ready
    );
endinterface

// File: rtl/acc_exec.sv
// Accumulator execution unit: applies a 3-bit control model to acc/EQ/memory/reg-write port.
// Latency 1 cycle for register models; memory models take ack latency + 1 (min 2 cycles).
// Backpressure: in_ready low while a memory request is outstanding; ACC_MEM_TIMEOUT_EN adds a 16-cycle abort.
module acc_exec (
    input  logic        clk,
    input  logic        rst_n,
    acc_exec_if.slave   issue,
    output logic [7:0]  acc,
    output logic        eq_flag,
    output logic        jump_valid,
    output logic [7:0]  jump_target,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        illegal
);

    typedef enum logic {IDLE, MEM} state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       eq_q, eq_d;
    logic       ill_q, ill_d;
    logic       jv_q, jv_d;
    logic [7:0] jt_q, jt_d;
    logic       rwe_q, rwe_d;
    logic [2:0] rwa_q, rwa_d;
    logic [7:0] rwd_q, rwd_d;
    logic       mwe_q, mwe_d;
    logic [7:0] maddr_q, maddr_d;
    logic [7:0] mwdata_q, mwdata_d;
    logic       done_q, done_d;
`ifdef ACC_MEM_TIMEOUT_EN
    logic [4:0] cnt_q, cnt_d;
`endif

    logic [7:0] alu_b;
    logic [7:0] alu_r;

    // Opcode group 010 is the immediate form of the ALU ops.
    assign alu_b = (issue.op[5:3] == 3'b010) ? issue.imm : issue.rs_val;

    always_comb begin
        alu_r = acc_q + alu_b;
        case (issue.op[1:0])
            2'b00: alu_r = acc_q + alu_b;
            2'b01: alu_r = acc_q - alu_b;
            2'b10: alu_r = acc_q & alu_b;
            2'b11: alu_r = acc_q | alu_b;
            default: alu_r = acc_q + alu_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        eq_d     = eq_q;
        ill_d    = ill_q;
        jv_d     = 1'b0;
        jt_d     = jt_q;
        rwe_d    = 1'b0;
        rwa_d    = rwa_q;
        rwd_d    = rwd_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        done_d   = 1'b0;
`ifdef ACC_MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue.in_valid) begin
                    done_d = 1'b1;
                    case (issue.acc_ctrl)
                        3'b000: ill_d = 1'b1;
                        3'b001: acc_d = alu_r;
                        3'b010: begin
                            if (issue.op[5:3] == 3'b110) begin
                                jv_d = 1'b1;
                                jt_d = acc_q;
                            end else if (issue.op[2:0] == 3'b101) begin
                                acc_d = {acc_q[6:0], 1'b0};
                            end else if (issue.op[2:0] == 3'b110) begin
                                acc_d = {1'b0, acc_q[7:1]};
                            end
                        end
                        3'b011: eq_d = (issue.rs_val == issue.rt_val);
                        3'b100: begin
                            if (eq_q) begin
                                jv_d = 1'b1;
                                jt_d = issue.imm;
                                eq_d = 1'b0;
                            end
                        end
                        3'b111: begin
                            rwe_d = 1'b1;
                            rwa_d = issue.rs_idx;
                            rwd_d = issue.imm;
                        end
                        default: begin
                            // Store (101) and load (110): retire later on the ack.
                            done_d   = 1'b0;
                            state_d  = MEM;
                            mwe_d    = ~issue.acc_ctrl[1];
                            maddr_d  = issue.imm;
                            mwdata_d = issue.acc_ctrl[1] ? mwdata_q : acc_q;
`ifdef ACC_MEM_TIMEOUT_EN
                            cnt_d    = 5'd0;
`endif
                        end
                    endcase
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!mwe_q) acc_d = mem_rdata;
`ifdef ACC_MEM_TIMEOUT_EN
                end else if (cnt_q == 5'd15) begin
                    state_d = IDLE;
                    ill_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 8'h00;
            eq_q     <= 1'b0;
            ill_q    <= 1'b0;
            jv_q     <= 1'b0;
            jt_q     <= 8'h00;
            rwe_q    <= 1'b0;
            rwa_q    <= 3'd0;
            rwd_q    <= 8'h00;
            mwe_q    <= 1'b0;
            maddr_q  <= 8'h00;
            mwdata_q <= 8'h00;
            done_q   <= 1'b0;
`ifdef ACC_MEM_TIMEOUT_EN
            cnt_q    <= 5'd0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            eq_q     <= eq_d;
            ill_q    <= ill_d;
            jv_q     <= jv_d;
            jt_q     <= jt_d;
            rwe_q    <= rwe_d;
            rwa_q    <= rwa_d;
            rwd_q    <= rwd_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            done_q   <= done_d;
`ifdef ACC_MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign issue.in_ready = (state_q == IDLE);
    assign mem_req        = (state_q == MEM);
    assign acc            = acc_q;
    assign eq_flag        = eq_q;
    assign illegal        = ill_q;
    assign jump_valid     = jv_q;
    assign jump_target    = jt_q;
    assign reg_we         = rwe_q;
    assign reg_waddr      = rwa_q;
    assign reg_wdata      = rwd_q;
    assign mem_we         = mwe_q;
    assign mem_addr       = maddr_q;
    assign mem_wdata      = mwdata_q;
    assign done           = done_q;

endmodule

// File: tb/tb_acc_exec.sv
// Directed bench for acc_exec: cycle model of the control models plus literal spot checks.
// The memory-timeout scenario is exercised only when ACC_MEM_TIMEOUT_EN is defined.
module tb_acc_exec;

    logic       clk;
    logic       rst_n;
    logic [7:0] acc, jump_target, reg_wdata, mem_addr, mem_wdata, mem_rdata;
    logic       eq_flag, jump_valid, reg_we, mem_req, mem_we, mem_ack, done, illegal;
    logic [2:0] reg_waddr;

    int n_vec = 0;
    int n_err = 0;

    acc_exec_if ifc ();

    acc_exec dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (ifc.slave),
        .acc         (acc),
        .eq_flag     (eq_flag),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .done        (done),
        .illegal     (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus an outstanding-memory record.
    logic [7:0] e_acc, e_jt, e_rwd, e_maddr, e_mwdata;
    logic [2:0] e_rwa;
    logic       e_eq, e_ill, e_jv, e_rwe, e_done, e_busy, e_store;
    int         e_wait;

    function automatic logic [7:0] f_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        case (f)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_acc <= 0; e_eq <= 0; e_ill <= 0; e_jv <= 0; e_jt <= 0;
            e_rwe <= 0; e_rwa <= 0; e_rwd <= 0; e_done <= 0; e_busy <= 0;
            e_store <= 0; e_maddr <= 0; e_mwdata <= 0; e_wait <= 0;
        end else begin
            e_done <= 0; e_jv <= 0; e_rwe <= 0;
            if (!e_busy && ifc.in_valid) begin
                case (ifc.acc_ctrl)
                    3'd0: begin e_ill <= 1; e_done <= 1; end
                    3'd1: begin
                        e_acc  <= f_alu(e_acc, (ifc.op[5:3] == 3'b010) ? ifc.imm : ifc.rs_val, ifc.op[1:0]);
                        e_done <= 1;
                    end
                    3'd2: begin
                        if (ifc.op[5:3] == 3'b110) begin e_jv <= 1; e_jt <= e_acc; end
                        else if (ifc.op[2:0] == 3'b101) e_acc <= e_acc * 2;
                        else if (ifc.op[2:0] == 3'b110) e_acc <= e_acc / 2;
                        e_done <= 1;
                    end
                    3'd3: begin e_eq <= (ifc.rs_val == ifc.rt_val); e_done <= 1; end
                    3'd4: begin
                        if (e_eq) begin e_jv <= 1; e_jt <= ifc.imm; e_eq <= 0; end
                        e_done <= 1;
                    end
                    3'd5: begin e_busy <= 1; e_store <= 1; e_maddr <= ifc.imm; e_mwdata <= e_acc; e_wait <= 0; end
                    3'd6: begin e_busy <= 1; e_store <= 0; e_maddr <= ifc.imm; e_wait <= 0; end
                    default: begin e_rwe <= 1; e_rwa <= ifc.rs_idx; e_rwd <= ifc.imm; e_done <= 1; end
                endcase
            end else if (e_busy) begin
                if (mem_ack) begin
                    e_busy <= 0; e_done <= 1;
                    if (!e_store) e_acc <= mem_rdata;
                end
`ifdef ACC_MEM_TIMEOUT_EN
                else if (e_wait == 15) begin
                    e_busy <= 0; e_done <= 1; e_ill <= 1;
                end
`endif
                else e_wait <= e_wait + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("acc", acc, e_acc);
            chk("eq_flag", eq_flag, e_eq);
            chk("illegal", illegal, e_ill);
            chk("done", done, e_done);
            chk("jump_valid", jump_valid, e_jv);
            chk("reg_we", reg_we, e_rwe);
            chk("in_ready", ifc.in_ready, !e_busy);
            chk("mem_req", mem_req, e_busy);
            if (e_jv) chk("jump_target", jump_target, e_jt);
            if (e_rwe) begin
                chk("reg_waddr", reg_waddr, e_rwa);
                chk("reg_wdata", reg_wdata, e_rwd);
            end
            if (e_busy) begin
                chk("mem_we", mem_we, e_store);
                chk("mem_addr", mem_addr, e_maddr);
                if (e_store) chk("mem_wdata", mem_wdata, e_mwdata);
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [5:0] o, input logic [2:0] ri,
                         input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] im);
        ifc.in_valid = 1'b1;
        ifc.acc_ctrl = c;
        ifc.op       = o;
        ifc.rs_idx   = ri;
        ifc.rs_val   = rs;
        ifc.rt_val   = rt;
        ifc.imm      = im;
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.in_valid = 0; ifc.acc_ctrl = 0; ifc.op = 0; ifc.rs_idx = 0;
        ifc.rs_val = 0; ifc.rt_val = 0; ifc.imm = 0;
        mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        chk("rst_acc", acc, 8'h00);
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU add, then add-immediate with wrap
        issue(3'd1, 6'b000000, 0, 8'hF0, 0, 0);
        chk("add_acc", acc, 8'hF0);
        chk("add_done", done, 1);
        issue(3'd1, 6'b010000, 0, 0, 0, 8'h20);
        chk("addi_wrap", acc, 8'h10);
        chk("addi_done", done, 1);

        // AND/OR to load 0x81, then shifts, then sub wrap
        issue(3'd1, 6'b000010, 0, 8'h00, 0, 0);
        issue(3'd1, 6'b000011, 0, 8'h81, 0, 0);
        chk("or_acc", acc, 8'h81);
        issue(3'd2, 6'b000101, 0, 0, 0, 0);
        chk("shl", acc, 8'h02);
        issue(3'd2, 6'b000110, 0, 0, 0, 0);
        chk("shr", acc, 8'h01);
        issue(3'd1, 6'b000001, 0, 8'h03, 0, 0);
        chk("sub_wrap", acc, 8'hFE);
        issue(3'd2, 6'b000000, 0, 0, 0, 0);
        issue(3'd2, 6'b110000, 0, 0, 0, 0);
        chk("jr_valid", jump_valid, 1);
        chk("jr_target", jump_target, 8'hFE);

        // EQ then conditional jump twice
        issue(3'd3, 0, 0, 8'h33, 8'h33, 0);
        chk("eq_set", eq_flag, 1);
        issue(3'd4, 0, 0, 0, 0, 8'h40);
        chk("jmp_valid", jump_valid, 1);
        chk("jmp_target", jump_target, 8'h40);
        chk("jmp_eq_clr", eq_flag, 0);
        issue(3'd4, 0, 0, 0, 0, 8'h50);
        chk("jmp2_none", jump_valid, 0);
        issue(3'd3, 0, 0, 8'h12, 8'h13, 0);

        // Store with ack on the third MEM cycle; a held ALU op waits behind it
        issue(3'd1, 6'b000010, 0, 8'h00, 0, 0);
        issue(3'd1, 6'b000011, 0, 8'h5A, 0, 0);
        issue(3'd5, 0, 0, 0, 0, 8'h10);
        ifc.in_valid = 1; ifc.acc_ctrl = 3'd1; ifc.op = 6'b000000; ifc.rs_val = 8'h01;
        for (int i = 0; i < 3; i++) begin
            chk("st_req", mem_req, 1);
            chk("st_we", mem_we, 1);
            chk("st_addr", mem_addr, 8'h10);
            chk("st_wdata", mem_wdata, 8'h5A);
            chk("st_ready", ifc.in_ready, 0);
            if (i == 2) mem_ack = 1;
            @(negedge clk);
        end
        mem_ack = 0;
        chk("st_req_drop", mem_req, 0);
        chk("st_done", done, 1);
        @(negedge clk);
        ifc.in_valid = 0;
        chk("held_add", acc, 8'h5B);

        // Load acked in the first MEM cycle
        issue(3'd6, 0, 0, 0, 0, 8'h22);
        chk("ld_we", mem_we, 0);
        mem_ack = 1; mem_rdata = 8'hC3;
        @(negedge clk);
        mem_ack = 0;
        chk("ld_acc", acc, 8'hC3);
        chk("ld_done", done, 1);

        // LWRI, illegal, then stray ack in IDLE
        issue(3'd7, 0, 3'd5, 0, 0, 8'h7E);
        chk("lwri_we", reg_we, 1);
        chk("lwri_addr", reg_waddr, 3'd5);
        chk("lwri_data", reg_wdata, 8'h7E);
        issue(3'd0, 0, 0, 0, 0, 0);
        chk("ill_set", illegal, 1);
        chk("ill_acc", acc, 8'hC3);
        chk("ill_done", done, 1);
        issue(3'd1, 6'b010000, 0, 0, 0, 8'h01);
        chk("ill_sticky", illegal, 1);
        mem_ack = 1; mem_rdata = 8'hFF;
        @(negedge clk);
        mem_ack = 0;
        chk("idle_ack", acc, 8'hC4);

        // Reset during MEM
        issue(3'd6, 0, 0, 0, 0, 8'h30);
        chk("mr_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_drop", mem_req, 0);
        chk("mr_ready", ifc.in_ready, 1);
        chk("mr_acc", acc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_no_done", done, 0);

`ifdef ACC_MEM_TIMEOUT_EN
        issue(3'd6, 0, 0, 0, 0, 8'h44);
        for (int i = 0; i < 16; i++) begin
            chk("to_req", mem_req, 1);
            @(negedge clk);
        end
        chk("to_req_drop", mem_req, 0);
        chk("to_illegal", illegal, 1);
        chk("to_done", done, 1);
        chk("to_acc", acc, 8'h00);
`else
        issue(3'd6, 0, 0, 0, 0, 8'h44);
        repeat (20) @(negedge clk);
        chk("wait_req", mem_req, 1);
        mem_ack = 1; mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack = 0;
        chk("wait_acc", acc, 8'h99);
        chk("wait_illegal", illegal, 0);
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
